// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 UART transmitter (LSB first, idle high) with a small byte FIFO in front of the shifter.
// Ports: clk / rst_n (synchronous, active-low); txdata + dataValid push one byte per strobe;
//        uart_tx serial line; tx_busy frame in flight or bytes queued; fifo_full FIFO at capacity;
//        overflow one-cycle pulse when a push is dropped.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (11-bit frame).
module uart_byte_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] txdata,
   input  logic       dataValid,
   output logic       uart_tx,
   output logic       tx_busy,
   output logic       fifo_full,
   output logic       overflow
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif
   state_e        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          busy_q, ovf_q;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full, pop, push, baud_end;
`ifdef UART_TX_PARITY_EN
   logic          par_q;
`endif
   assign full     = cnt_q == (AW+1)'(FIFO_DEPTH);
   assign pop      = (state_q == IDLE) && (cnt_q != '0);
   // a push into a full FIFO still fits when the head leaves in the same cycle
   assign push     = dataValid && (!full || pop);
   assign baud_end = baud_q == BW'(CLKS_PER_BIT - 1);
   assign cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
   // line level is registered from the current state, so each bit appears one clk after its state begins
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = 1'b1;
      baud_d  = (state_q == IDLE || baud_end) ? '0 : baud_q + 1'b1;
      case (state_q)
         START: begin
            tx_d = 1'b0;
            if (baud_end) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            tx_d = shift_q[0];
            if (baud_end) begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
               if (bit_q == 3'd7) state_d = PARITY;
`else
               if (bit_q == 3'd7) state_d = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            tx_d = par_q;
            if (baud_end) state_d = STOP;
         end
`endif
         STOP: if (baud_end) state_d = IDLE;
         default: if (pop) begin
            shift_d = mem_q[rd_q];
            state_d = START;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= (state_q != IDLE) || (cnt_q != '0);
         ovf_q   <= dataValid && full && !pop;
         wr_q    <= wr_q + AW'(push);
         rd_q    <= rd_q + AW'(pop);
         cnt_q   <= cnt_d;
      end
   end
`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst_n) par_q <= 1'b0;
      else if (pop) par_q <= ^mem_q[rd_q];
   end
`endif
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= txdata;
   end
   assign uart_tx   = tx_q;
   assign tx_busy   = busy_q;
   assign fifo_full = full;
   assign overflow  = ovf_q;
endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: directed bench for uart_byte_tx with a line receiver checking frames against a byte scoreboard.
module tb_uart_byte_tx;
   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       dataValid = 1'b0;
   logic [7:0] txdata = 8'h00;
   logic       uart_tx, tx_busy, fifo_full, overflow;
   int         vecs = 0, errs = 0, n_frames = 0, n_starts = 0, n_ovf = 0, pos = -1, mb = 0;
   int         f0, s0, o0;
   logic [7:0] sb [$];
   logic       prev_tx = 1'b1;
   logic [7:0] rx = 8'h00;
   logic [7:0] bt;
   logic [10:0] fr;

   uart_byte_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .txdata(txdata), .dataValid(dataValid),
      .uart_tx(uart_tx), .tx_busy(tx_busy), .fifo_full(fifo_full), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag, input int bound);
      int c = 0;
      while (sb.size() != 0 && c < bound) begin
         step();
         c++;
      end
      chk(tag, sb.size(), 0);
   endtask

   // receiver: samples mid-bit on falling clk edges, pops the expected byte at the stop bit
   always @(negedge clk) begin
      if (!rst_n) pos = -1;
      else if (pos >= 0) pos++;
      else if (prev_tx && !uart_tx) begin
         pos = 0;
         n_starts++;
      end
      if (rst_n && overflow) n_ovf++;
      if (pos >= 0 && pos % CPB == CPB / 2) begin
         mb = pos / CPB;
         if (mb == 0) chk("start_bit", uart_tx, 0);
         else if (mb <= 8) rx[mb-1] = uart_tx;
         else if (mb == NB - 1) begin
            chk("stop_bit", uart_tx, 1);
            chk("sb_has_entry", sb.size() != 0, 1);
            if (sb.size() != 0) chk("rx_byte", rx, sb.pop_front());
            n_frames++;
         end else chk("parity_bit", uart_tx, ^rx);
      end
      if (pos == CPB * NB - 1) pos = -1;
      prev_tx = uart_tx;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, vectors %0d", vecs);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset
      step(3);
      chk("rst_uart_tx", uart_tx, 1);
      chk("rst_tx_busy", tx_busy, 0);
      chk("rst_fifo_full", fifo_full, 0);
      chk("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      step(2);
      // single byte 0xA5: latency and exact line waveform
      bt = 8'hA5;
`ifdef UART_TX_PARITY_EN
      fr = {1'b1, ^bt, bt, 1'b0};
`else
      fr = {2'b11, bt, 1'b0};
`endif
      sb.push_back(bt);
      txdata = bt;
      dataValid = 1'b1;
      step();
      dataValid = 1'b0;
      step();
      chk("lat_n1_line_high", uart_tx, 1);
      chk("lat_n1_busy", tx_busy, 1);
      step();
      chk("lat_n2_start", uart_tx, 0);
      for (int k = 0; k < NB; k++) begin
         if (k > 0) step(CPB);
         chk($sformatf("a5_bit%0d", k), uart_tx, fr[k]);
      end
      step(CPB - 1);
      chk("a5_busy_last", tx_busy, 1);
      step();
      chk("a5_busy_fall", tx_busy, 0);
      chk("a5_sb_empty", sb.size(), 0);
      // back-to-back pushes on consecutive cycles
      f0 = n_frames;
      for (int i = 0; i < 4; i++) begin
         txdata = 8'h14 + 8'(i);
         sb.push_back(txdata);
         dataValid = 1'b1;
         step();
         chk("b2b_no_ovf", overflow, 0);
      end
      dataValid = 1'b0;
      drain("b2b_drain", 250);
      chk("b2b_frames", n_frames - f0, 4);
      chk("b2b_ovf_pulses", n_ovf, 0);
      step(10);
      chk("b2b_idle_busy", tx_busy, 0);
      // overflow: six pushes, the sixth dropped
      f0 = n_frames;
      for (int i = 0; i < 6; i++) begin
         txdata = 8'h30 + 8'(i);
         if (i < 5) sb.push_back(txdata);
         dataValid = 1'b1;
         step();
         if (i == 4) begin
            chk("ovf_full", fifo_full, 1);
            chk("ovf_not_yet", overflow, 0);
         end
         if (i == 5) chk("ovf_pulse", overflow, 1);
      end
      dataValid = 1'b0;
      step();
      chk("ovf_pulse_end", overflow, 0);
      drain("ovf_drain", 400);
      step(60);
      chk("ovf_frames", n_frames - f0, 5);
      chk("ovf_pulses", n_ovf, 1);
      chk("ovf_idle_busy", tx_busy, 0);
      // reset in the middle of data bit 3
      txdata = 8'h52;
      sb.push_back(txdata);
      dataValid = 1'b1;
      step();
      txdata = 8'h33;
      sb.push_back(txdata);
      step();
      dataValid = 1'b0;
      step(18);
      chk("mid_bit3_line", uart_tx, 0);
      chk("mid_busy", tx_busy, 1);
      rst_n = 1'b0;
      step();
      chk("midrst_line_high", uart_tx, 1);
      chk("midrst_busy", tx_busy, 0);
      chk("midrst_full", fifo_full, 0);
      rst_n = 1'b1;
      sb.delete();
      s0 = n_starts;
      o0 = n_ovf;
      step(100);
      chk("midrst_no_frames", n_starts - s0, 0);
      chk("midrst_line_idle", uart_tx, 1);
      chk("midrst_idle_busy", tx_busy, 0);
      chk("midrst_no_ovf", n_ovf - o0, 0);
      // parity patterns (frame content checked by the receiver)
      f0 = n_frames;
      txdata = 8'h07;
      sb.push_back(txdata);
      dataValid = 1'b1;
      step();
      txdata = 8'h03;
      sb.push_back(txdata);
      step();
      dataValid = 1'b0;
      drain("par_drain", 150);
      step(10);
      chk("par_frames", n_frames - f0, 2);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
